mem_port_arbiter: RTL

- Shares the single 64K x 8 emulated RAM/ROM port between three requesters:
  - CPU bus shadow access (port 0)
  - diagnostics SPI engine (port 1, memory dump/load)
  - video-RAM mirror fetch (port 2)
- Sits between the requesters and the memory block; drives the memory address, data, write-enable and chip-select.
- Sequences every access as a fixed-length cycle with a one-cycle release gap.

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter_arb_pick.sv | 35 +++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// Contents: port index constants, the arbiter state encoding, and a helper
// that turns a port index into a one-hot request/ack vector.
package mem_arb_pkg;

  localparam logic [1:0] PORT_CPU   = 2'd0;
  localparam logic [1:0] PORT_DIAG  = 2'd1;
  localparam logic [1:0] PORT_VRAM  = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RELEASE
  } arb_state_t;

  function automatic logic [2:0] port_onehot(input logic [1:0] p);
    logic [2:0] oh;
    oh = '0;
    case (p)
      PORT_CPU:  oh = 3'b001;
      PORT_DIAG: oh = 3'b010;
      PORT_VRAM: oh = 3'b100;
      default:   oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the three requesters, the arbiter and the memory block.
// Requester side: req/addr0..2/we/wdata0..2 in, ack/rdata/owner/busy out.
// Memory side: mem_address/mem_data_out/mem_we/mem_cs out, mem_data_in in.
// Modports: master = requesters + memory (the arbiter's environment),
//           slave  = the arbiter itself.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [2:0]        req;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [2:0]        we;
  logic [7:0]        wdata0;
  logic [7:0]        wdata1;
  logic [7:0]        wdata2;
  logic [2:0]        ack;
  logic [7:0]        rdata;
  logic [1:0]        owner;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_data_out;
  logic [7:0]        mem_data_in;
  logic              mem_we;
  logic              mem_cs;

  modport master (
    output req, addr0, addr1, addr2, we, wdata0, wdata1, wdata2, mem_data_in,
    input  ack, rdata, owner, busy, mem_address, mem_data_out, mem_we, mem_cs
  );

  modport slave (
    input  req, addr0, addr1, addr2, we, wdata0, wdata1, wdata2, mem_data_in,
    output ack, rdata, owner, busy, mem_address, mem_data_out, mem_we, mem_cs
  );
endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select for the memory port arbiter.
// Ports: req (per-port request), rr_vram (round-robin pointer, 1 = vram next),
//        starve (per low port: at wait limit and requesting; bit0 diag,
//        bit1 vram), winner (port index, OWNER_NONE if idle), valid.
// Starved ports beat the CPU; otherwise CPU has fixed priority and diag/vram
// share by round robin.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic       rr_vram,
  input  logic [1:0] starve,
  output logic [1:0] winner,
  output logic       valid
);
  always_comb begin
    winner = OWNER_NONE;
    valid  = |req;
    if (starve[0] && starve[1]) begin
      winner = rr_vram ? PORT_VRAM : PORT_DIAG;
    end else if (starve[0]) begin
      winner = PORT_DIAG;
    end else if (starve[1]) begin
      winner = PORT_VRAM;
    end else if (req[0]) begin
      winner = PORT_CPU;
    end else if (req[1] && req[2]) begin
      winner = rr_vram ? PORT_VRAM : PORT_DIAG;
    end else if (req[1]) begin
      winner = PORT_DIAG;
    end else if (req[2]) begin
      winner = PORT_VRAM;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64K x 8 memory port between CPU shadow (port 0), diagnostics
// SPI (port 1) and video-RAM mirror fetch (port 2). Each access holds
// mem_cs for ACCESS_CYCLES cycles followed by a one-cycle release gap.
// Ports: fpga_clk, fpga_reset (async, active low), bus (slave modport of
//        mem_port_arbiter_if carrying requester and memory signals).
// Optional feature: define ARB_STARVE_GUARD_EN to let diag/vram override the
// CPU after STARVE_LIMIT lost arbitrations.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic             fpga_clk,
  input  logic             fpga_reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned     CNT_W    = $clog2(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  if (ACCESS_CYCLES < 2 || STARVE_LIMIT < 1) begin : g_param_check
    $error("mem_port_arbiter: ACCESS_CYCLES must be >= 2 and STARVE_LIMIT >= 1");
  end

  arb_state_t        state, state_d;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        own_q;
  logic              we_q;
  logic              rr_vram;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        rdata_q;
  logic [1:0]        winner;
  logic [1:0]        starve;
  logic              pick_valid;
  logic              last;
  logic              in_access;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic [7:0]        win_wdata;

  arb_pick u_pick (
    .req    (bus.req),
    .rr_vram(rr_vram),
    .starve (starve),
    .winner (winner),
    .valid  (pick_valid)
  );

  assign last      = (cnt == CNT_LAST);
  assign in_access = (state == ARB_ACCESS);

  always_comb begin
    state_d = state;
    unique case (state)
      ARB_IDLE:    if (pick_valid) state_d = ARB_ACCESS;
      ARB_ACCESS:  if (last) state_d = ARB_RELEASE;
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    win_addr  = bus.addr0;
    win_we    = bus.we[0];
    win_wdata = bus.wdata0;
    case (winner)
      PORT_DIAG: begin
        win_addr  = bus.addr1;
        win_we    = bus.we[1];
        win_wdata = bus.wdata1;
      end
      PORT_VRAM: begin
        win_addr  = bus.addr2;
        win_we    = bus.we[2];
        win_wdata = bus.wdata2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge fpga_clk or negedge fpga_reset) begin
    if (!fpga_reset) begin
      state   <= ARB_IDLE;
      cnt     <= '0;
      own_q   <= OWNER_NONE;
      we_q    <= 1'b0;
      rr_vram <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            own_q   <= winner;
            addr_q  <= win_addr;
            we_q    <= win_we;
            wdata_q <= win_wdata;
            cnt     <= '0;
            if (winner == PORT_DIAG)      rr_vram <= 1'b1;
            else if (winner == PORT_VRAM) rr_vram <= 1'b0;
          end
        end
        ARB_ACCESS: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last && !we_q) rdata_q <= bus.mem_data_in;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the registered state so an async reset clears them at once.
  // During the ack cycle of a read, rdata forwards mem_data_in so it is valid
  // alongside ack; rdata_q holds it afterwards.
  assign bus.mem_cs       = in_access;
  assign bus.mem_we       = in_access && we_q && !last;
  assign bus.owner        = in_access ? own_q : OWNER_NONE;
  assign bus.busy         = in_access;
  assign bus.ack          = (in_access && last) ? port_onehot(own_q) : 3'b000;
  assign bus.rdata        = (in_access && last && !we_q) ? bus.mem_data_in : rdata_q;
  assign bus.mem_address  = addr_q;
  assign bus.mem_data_out = wdata_q;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned       WAIT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] wait_diag;
  logic [WAIT_W-1:0] wait_vram;

  assign starve = {bus.req[PORT_VRAM] && (wait_vram == WAIT_MAX),
                   bus.req[PORT_DIAG] && (wait_diag == WAIT_MAX)};

  // Counters only move on grant cycles; a loss to the other low port does not count.
  always_ff @(posedge fpga_clk or negedge fpga_reset) begin
    if (!fpga_reset) begin
      wait_diag <= '0;
      wait_vram <= '0;
    end else if (state == ARB_IDLE && pick_valid) begin
      if (winner == PORT_DIAG)
        wait_diag <= '0;
      else if (winner == PORT_CPU && bus.req[PORT_DIAG] && wait_diag != WAIT_MAX)
        wait_diag <= wait_diag + 1'b1;
      if (winner == PORT_VRAM)
        wait_vram <= '0;
      else if (winner == PORT_CPU && bus.req[PORT_VRAM] && wait_vram != WAIT_MAX)
        wait_vram <= wait_vram + 1'b1;
    end
  end
`else
  assign starve = 2'b00;
`endif

endmodule
